// File: rtl/keypoint_stream_reader.sv
// keypoint_stream_reader
// Runs after a detect pass. It reads keypoint SRAM 1 (layer 0) and then keypoint SRAM 2
// (layer 1), and streams every stored {row,col} word with its layer tag over a valid/ready
// interface. A small output FIFO absorbs the one-cycle SRAM read latency and consumer backpressure.
//
// Ports
//   clk_i         clock; all logic runs on the rising edge
//   rst_n_i       synchronous reset, active HIGH (resets while rst_n_i == 1)
//   start_i       one-cycle pulse; latches the counts and begins a readout pass (ignored while busy)
//   kp1_count_i   number of valid words in SRAM 1
//   kp2_count_i   number of valid words in SRAM 2
//   kp1_addr_o    read address for SRAM 1; kp1_dout_i is valid one cycle later
//   kp2_addr_o    read address for SRAM 2; kp2_dout_i is valid one cycle later
//   busy_o        high from the cycle after start until the pass completes
//   kp_valid_o    kp_data_o holds a keypoint (FIFO not empty)
//   kp_ready_i    consumer accept; a beat transfers when kp_valid_o && kp_ready_i
//   kp_data_o     {layer, row, col}
//   kp_last_o     marks the final keypoint of the pass
//   done_o        one-cycle pulse at the end of a pass
module keypoint_stream_reader #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned ROW_W      = 9,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic [ADDR_W-1:0]      kp1_count_i,
  input  logic [ADDR_W-1:0]      kp2_count_i,
  output logic [ADDR_W-1:0]      kp1_addr_o,
  input  logic [ROW_W+COL_W-1:0] kp1_dout_i,
  output logic [ADDR_W-1:0]      kp2_addr_o,
  input  logic [ROW_W+COL_W-1:0] kp2_dout_i,
  output logic                   busy_o,
  output logic                   kp_valid_o,
  input  logic                   kp_ready_i,
  output logic [ROW_W+COL_W:0]   kp_data_o,
  output logic                   kp_last_o,
  output logic                   done_o
);

  localparam int unsigned DataW  = ROW_W + COL_W;
  localparam int unsigned EntryW = DataW + 2;  // {last, layer, row, col}
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OccW   = CntW + 1;
  localparam int unsigned IdxW   = ADDR_W + 1;

  typedef enum logic [2:0] {StIdle, StRd1, StRd2, StDrain, StFin} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt1_q, cnt2_q;
  logic [ADDR_W-1:0] addr1_q, addr2_q;
  logic [IdxW-1:0]   total_q, emit_idx_q;
  logic              inflight_q, inflight_layer_q;
  logic              busy_q, done_q;
  logic [EntryW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   fifo_cnt_q;

  logic              push, pop, room, issue1, issue2, push_last;
  logic [CntW-1:0]   occ_after_pop, fifo_cnt_d;
  logic [EntryW-1:0] head, push_entry;

  assign kp_valid_o = (fifo_cnt_q != '0);
  assign kp_data_o  = head[DataW:0];
  assign kp_last_o  = head[DataW+1] & kp_valid_o;
  assign kp1_addr_o = addr1_q;
  assign kp2_addr_o = addr2_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

  always_comb begin
    head          = fifo_mem_q[rd_ptr_q];
    push          = inflight_q;
    pop           = kp_valid_o & kp_ready_i;
    // A pop in this cycle frees a slot in time for a read issued now, which keeps the
    // two-entry FIFO streaming at one beat per cycle.
    occ_after_pop = fifo_cnt_q - CntW'(pop);
    room          = ({1'b0, occ_after_pop} + OccW'(inflight_q)) < OccW'(FIFO_DEPTH);
    issue1        = (state_q == StRd1) && (addr1_q < cnt1_q) && room;
    issue2        = (state_q == StRd2) && (addr2_q < cnt2_q) && room;
    fifo_cnt_d    = fifo_cnt_q + CntW'(push) - CntW'(pop);
    // Pushes happen in emission order, so the push index doubles as the emission index.
    push_last     = (emit_idx_q == total_q - IdxW'(1));
    push_entry    = {push_last, inflight_layer_q, inflight_layer_q ? kp2_dout_i : kp1_dout_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      state_q          <= StIdle;
      cnt1_q           <= '0;
      cnt2_q           <= '0;
      addr1_q          <= '0;
      addr2_q          <= '0;
      total_q          <= '0;
      emit_idx_q       <= '0;
      inflight_q       <= 1'b0;
      inflight_layer_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      fifo_cnt_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue1 | issue2;
      if (issue1) begin
        addr1_q          <= addr1_q + ADDR_W'(1);
        inflight_layer_q <= 1'b0;
      end
      if (issue2) begin
        addr2_q          <= addr2_q + ADDR_W'(1);
        inflight_layer_q <= 1'b1;
      end
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
        emit_idx_q           <= emit_idx_q + IdxW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      fifo_cnt_q <= fifo_cnt_d;

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            cnt1_q     <= kp1_count_i;
            cnt2_q     <= kp2_count_i;
            total_q    <= IdxW'(kp1_count_i) + IdxW'(kp2_count_i);
            addr1_q    <= '0;
            addr2_q    <= '0;
            emit_idx_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= (kp1_count_i == '0 && kp2_count_i == '0) ? StFin : StRd1;
          end
        end
        StRd1: begin
          // Leave on the final issue itself so RD2 can issue on the very next cycle.
          if ((addr1_q == cnt1_q) || (issue1 && (addr1_q + ADDR_W'(1) == cnt1_q))) begin
            state_q <= StRd2;
          end
        end
        StRd2: begin
          if ((addr2_q == cnt2_q) || (issue2 && (addr2_q + ADDR_W'(1) == cnt2_q))) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // No issues in DRAIN, so an empty next-cycle FIFO means nothing is left in flight.
          if (fifo_cnt_d == '0) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_keypoint_stream_reader.sv
// Directed bench for keypoint_stream_reader: behavioural SRAM models, a streaming checker that
// compares every beat with the SRAM contents in layer/address order, and directed reset, empty-pass,
// backpressure, full-size and mid-pass-reset sequences.
module tb_keypoint_stream_reader;

  localparam int ADDR_W = 11;
  localparam int ROW_W  = 9;
  localparam int COL_W  = 10;
  localparam int DW     = ROW_W + COL_W;

  logic              clk = 1'b0;
  logic              rst_n, start, kp_ready;
  logic [ADDR_W-1:0] kp1_count, kp2_count, kp1_addr, kp2_addr;
  logic [DW-1:0]     kp1_dout, kp2_dout;
  logic              busy, kp_valid, kp_last, done;
  logic [DW:0]       kp_data;

  logic [DW-1:0]     mem1 [2048];
  logic [DW-1:0]     mem2 [2048];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypoint_stream_reader #(
    .ADDR_W     (ADDR_W),
    .ROW_W      (ROW_W),
    .COL_W      (COL_W),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .kp1_count_i (kp1_count),
    .kp2_count_i (kp2_count),
    .kp1_addr_o  (kp1_addr),
    .kp1_dout_i  (kp1_dout),
    .kp2_addr_o  (kp2_addr),
    .kp2_dout_i  (kp2_dout),
    .busy_o      (busy),
    .kp_valid_o  (kp_valid),
    .kp_ready_i  (kp_ready),
    .kp_data_o   (kp_data),
    .kp_last_o   (kp_last),
    .done_o      (done)
  );

  // Synchronous-read SRAMs: data valid one cycle after the address.
  always @(posedge clk) begin
    kp1_dout <= mem1[kp1_addr];
    kp2_dout <= mem2[kp2_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 = ready always high, 1 = ready pattern 1,0,0 repeating, 2 = random ready.
  task automatic run_pass(input string name, input int n1, input int n2, input int mode,
                          input bit restart, input int budget);
    int          total, beats, dones, last_cyc, done_cyc, max_occ, occ;
    bit          stalled, r;
    logic [DW:0] held, exp_data;
    total    = n1 + n2;
    beats    = 0;
    dones    = 0;
    last_cyc = -100;
    done_cyc = -1;
    max_occ  = 0;
    stalled  = 1'b0;
    held     = '0;
    kp1_count = ADDR_W'(n1);
    kp2_count = ADDR_W'(n2);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    // Counts must only be sampled on start; scramble them afterwards.
    kp1_count = 11'd5;
    kp2_count = 11'd6;
    chk({name, " busy during pass"}, busy, 1);
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (done) begin
        dones++;
        done_cyc = cyc;
        break;
      end
      if (stalled) begin
        chk({name, " held valid"}, kp_valid, 1);
        chk({name, " held data"}, kp_data, held);
      end
      occ = int'(kp1_addr) + int'(kp2_addr) - beats;
      if (occ > max_occ) max_occ = occ;
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      kp_ready = r;
      if (kp_valid && r) begin
        exp_data = (beats < n1) ? {1'b0, mem1[beats]} : {1'b1, mem2[beats - n1]};
        chk({name, " data"}, kp_data, exp_data);
        chk({name, " last"}, kp_last, (beats == total - 1));
        beats++;
        last_cyc = cyc;
      end
      stalled = kp_valid && !r;
      held    = kp_data;
      start   = restart && (cyc == 2);
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, " done pulses"}, dones, 1);
    chk({name, " beat count"}, beats, total);
    chk({name, " done latency"}, (done_cyc - last_cyc >= 1) && (done_cyc - last_cyc <= 3), 1);
    chk({name, " max occupancy"}, max_occ <= 2, 1);
    chk({name, " busy after done"}, busy, 0);
    @(negedge clk);
    chk({name, " done width"}, done, 0);
    chk({name, " valid after pass"}, kp_valid, 0);
    kp_ready = 1'b1;
  endtask

  initial begin
    int dseen;
    rst_n     = 1'b1;
    start     = 1'b0;
    kp_ready  = 1'b1;
    kp1_count = '0;
    kp2_count = '0;
    for (int i = 0; i < 2048; i++) begin
      mem1[i] = {9'(i % 480), 10'(1023 - (i % 1024))};
      mem2[i] = {9'((i * 7) % 512), 10'(i % 1000)};
    end
    mem1[0] = {9'd5, 10'd7};
    mem1[1] = {9'd5, 10'd9};
    mem1[2] = {9'd100, 10'd639};
    mem2[0] = {9'd0, 10'd1};
    mem2[1] = {9'd479, 10'd3};

    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    chk("reset kp_valid", kp_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset kp_last", kp_last, 0);
    chk("reset kp_data", kp_data, 0);
    chk("reset kp1_addr", kp1_addr, 0);
    chk("reset kp2_addr", kp2_addr, 0);

    // Mixed layers, ready high.
    run_pass("t1", 3, 2, 0, 1'b0, 100);
    chk("t1 kp1_addr hold", kp1_addr, 3);
    chk("t1 kp2_addr hold", kp2_addr, 2);

    // Both counts zero: busy for exactly one cycle, done two cycles after start.
    kp1_count = '0;
    kp2_count = '0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t2 busy cycle1", busy, 1);
    chk("t2 done cycle1", done, 0);
    chk("t2 valid cycle1", kp_valid, 0);
    @(negedge clk);
    chk("t2 busy cycle2", busy, 0);
    chk("t2 done cycle2", done, 1);
    chk("t2 valid cycle2", kp_valid, 0);
    @(negedge clk);
    chk("t2 done cycle3", done, 0);
    chk("t2 valid cycle3", kp_valid, 0);

    // SRAM 2 only.
    run_pass("t3", 0, 4, 0, 1'b0, 100);
    chk("t3 kp1_addr", kp1_addr, 0);
    chk("t3 kp2_addr", kp2_addr, 4);

    // SRAM 1 only, ready 1,0,0 pattern, plus a start pulse while busy that must be ignored.
    run_pass("t4", 4, 0, 1, 1'b1, 200);
    chk("t4 kp1_addr", kp1_addr, 4);

    // Full-size pass with random backpressure.
    run_pass("t5", 2047, 2047, 2, 1'b0, 40000);

    // Reset while stalled in RD2.
    kp_ready  = 1'b0;
    kp1_count = 11'd1;
    kp2_count = 11'd5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6 pre kp2_addr", kp2_addr, 1);
    chk("t6 pre kp_valid", kp_valid, 1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    chk("t6 rst kp_valid", kp_valid, 0);
    chk("t6 rst busy", busy, 0);
    chk("t6 rst kp2_addr", kp2_addr, 0);
    kp_ready = 1'b1;
    dseen    = 0;
    repeat (5) begin
      if (done) dseen++;
      @(negedge clk);
    end
    chk("t6 no done", dseen, 0);
    run_pass("t6 restart", 2, 1, 0, 1'b0, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
